// File: rtl/wb_master08.sv
// 8-bit Wishbone initiator: turns one local command into a single read, single write
// or locked read-modify-write bus cycle, with a wait-state timeout.
module wb_master08 #(
  parameter int AW      = 8,
  parameter int TIMEOUT = 16,
  parameter int TW      = 8
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          CMD_VLD,
  output logic          CMD_RDY,
  input  logic          CMD_WE,
  input  logic          CMD_RMW,
  input  logic [AW-1:0] CMD_ADR,
  input  logic [7:0]    CMD_DAT,
  input  logic [7:0]    CMD_MSK,
  output logic          RSP_VLD,
  output logic [7:0]    RSP_DAT,
  output logic          RSP_ERR,
  output logic          CYC_O,
  output logic          STB_O,
  output logic          WE_O,
  output logic [AW-1:0] ADR_O,
  output logic [7:0]    DAT_O,
  input  logic [7:0]    DAT_I,
  input  logic          ACK_I,
  input  logic          ERR_I
);

  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_GAP, RMW_WR} state_t;

  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_t        state, state_nx;
  logic          cyc_nx, stb_nx, we_nx, rsp_vld_nx, rsp_err_nx;
  logic [AW-1:0] adr_nx;
  logic [7:0]    dat_nx, rsp_dat_nx;
  logic [7:0]    cdat, cdat_nx, msk, msk_nx;
  logic [TW-1:0] cnt, cnt_nx;
  logic          done, done_err;

  assign CMD_RDY = (state == IDLE);

  always_comb begin
    state_nx   = state;
    cyc_nx     = CYC_O;
    stb_nx     = STB_O;
    we_nx      = WE_O;
    adr_nx     = ADR_O;
    dat_nx     = DAT_O;
    rsp_vld_nx = 1'b0;
    rsp_dat_nx = RSP_DAT;
    rsp_err_nx = RSP_ERR;
    cdat_nx    = cdat;
    msk_nx     = msk;
    cnt_nx     = cnt;
    done       = 1'b0;
    done_err   = 1'b0;
    case (state)
      IDLE: begin
        if (CMD_VLD) begin
          adr_nx  = CMD_ADR;
          dat_nx  = CMD_DAT;
          cdat_nx = CMD_DAT;
          msk_nx  = CMD_MSK;
          cnt_nx  = '0;
          cyc_nx  = 1'b1;
          stb_nx  = 1'b1;
          if (CMD_RMW) begin
            state_nx = RMW_RD;
            we_nx    = 1'b0;
          end else if (CMD_WE) begin
            state_nx = WR;
            we_nx    = 1'b1;
          end else begin
            state_nx = RD;
            we_nx    = 1'b0;
          end
        end
      end
      RMW_GAP: begin
        // CYC_O stays high so the bus is held across read and write halves
        state_nx = RMW_WR;
        stb_nx   = 1'b1;
        we_nx    = 1'b1;
        cnt_nx   = '0;
      end
      default: begin
        if (STB_O && ERR_I) begin
          done     = 1'b1;
          done_err = 1'b1;
        end else if (STB_O && ACK_I) begin
          case (state)
            RD: begin
              rsp_dat_nx = DAT_I;
              done       = 1'b1;
            end
            WR: begin
              rsp_dat_nx = DAT_O;
              done       = 1'b1;
            end
            RMW_RD: begin
              rsp_dat_nx = DAT_I;
              dat_nx     = (DAT_I & ~msk) | (cdat & msk);
              state_nx   = RMW_GAP;
              stb_nx     = 1'b0;
              we_nx      = 1'b0;
            end
            RMW_WR:  done = 1'b1;
            default: ;
          endcase
        end else if (STB_O) begin
          if (TIMEOUT != 0 && cnt == TO_LAST) begin
            done     = 1'b1;
            done_err = 1'b1;
          end else begin
            cnt_nx = cnt + TW'(1);
          end
        end
      end
    endcase
    if (done) begin
      state_nx   = IDLE;
      cyc_nx     = 1'b0;
      stb_nx     = 1'b0;
      we_nx      = 1'b0;
      rsp_vld_nx = 1'b1;
      rsp_err_nx = done_err;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state   <= IDLE;
      CYC_O   <= 1'b0;
      STB_O   <= 1'b0;
      WE_O    <= 1'b0;
      ADR_O   <= '0;
      DAT_O   <= '0;
      RSP_VLD <= 1'b0;
      RSP_DAT <= '0;
      RSP_ERR <= 1'b0;
      cdat    <= '0;
      msk     <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nx;
      CYC_O   <= cyc_nx;
      STB_O   <= stb_nx;
      WE_O    <= we_nx;
      ADR_O   <= adr_nx;
      DAT_O   <= dat_nx;
      RSP_VLD <= rsp_vld_nx;
      RSP_DAT <= rsp_dat_nx;
      RSP_ERR <= rsp_err_nx;
      cdat    <= cdat_nx;
      msk     <= msk_nx;
      cnt     <= cnt_nx;
    end
  end

endmodule
